// File: rtl/mips_pkg.sv
// Shared MIPS-32 datapath definitions: ALUOp codes, funct constants,
// ALU control encodings and default operand/register-address widths.
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // Control word driven onto the ALU: {A_invert, B_negate, Operation}.
  typedef struct packed {
    logic       a_invert;
    logic       b_negate;
    logic [1:0] operation;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_CTRL_AND = 4'b0000;
  localparam alu_ctrl_t ALU_CTRL_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_CTRL_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_CTRL_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_CTRL_SLT = 4'b0111;
  localparam alu_ctrl_t ALU_CTRL_NOR = 4'b1100;

endpackage

// File: rtl/alu_control_dec.sv
// Combinational ALUOp/funct decode into the ALU control word. Unsupported
// encodings fall back to ADD and raise illegal.
module alu_control_dec
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_t  ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ALU_CTRL_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD: ctrl = ALU_CTRL_ADD;
      ALU_OP_SUB: ctrl = ALU_CTRL_SUB;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_CTRL_ADD;
          FUNCT_SUB: ctrl = ALU_CTRL_SUB;
          FUNCT_AND: ctrl = ALU_CTRL_AND;
          FUNCT_OR:  ctrl = ALU_CTRL_OR;
          FUNCT_SLT: ctrl = ALU_CTRL_SLT;
          FUNCT_NOR: ctrl = ALU_CTRL_NOR;
          default: begin
            ctrl    = ALU_CTRL_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl    = ALU_CTRL_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: registered operands/control,
// optional EX/MEM + MEM/WB forwarding enabled by ID_EX_FORWARDING_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_a_invert,
  output logic              alu_b_negate,
  output logic [1:0]        alu_operation,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  // Handshake: a transfer into EX happens on a cycle with in_valid & in_ready.
  // in_ready depends only on EX occupancy and ex_ready (never on flush or
  // in_valid); flush squashes the transfer and empties EX at the next edge.
  alu_ctrl_t         id_ctrl;
  logic              id_illegal;
  logic              load;

  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] dest_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              illegal_q;
  alu_ctrl_t         ctrl_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  alu_control_dec u_alu_control_dec (
    .alu_op  (id_alu_op),
    .funct   (id_funct),
    .ctrl    (id_ctrl),
    .illegal (id_illegal)
  );

  assign in_ready = !ex_valid || ex_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Payload only moves on a load, so a stalled instruction stays frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      ctrl_q      <= ALU_CTRL_ADD;
    end else if (load) begin
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      dest_q      <= id_reg_dst ? id_rd : id_rt;
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write;
      illegal_q   <= id_illegal;
      ctrl_q      <= id_ctrl;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; $zero never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd == rs_q) && (rs_q != '0)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rs_q) && (rs_q != '0)) begin
      fwd_rs = memwb_data;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd == rt_q) && (rt_q != '0)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rt_q) && (rt_q != '0)) begin
      fwd_rt = memwb_data;
    end
  end
`else
  // Hazards are covered by hazard-unit stalls; forward sources are ignored.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_data, rs_q, rt_q};
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
`endif

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign alu_a_invert  = ctrl_q.a_invert;
  assign alu_b_negate  = ctrl_q.b_negate;
  assign alu_operation = ctrl_q.operation;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = ex_valid && reg_write_q;
  assign ex_illegal    = ex_valid && illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the
// ID_EX_FORWARDING_EN setting the design is built with.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src, id_reg_dst, id_reg_write;
  logic          flush, ex_ready;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_data;
  logic          ex_valid;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_a_invert, alu_b_negate;
  logic [1:0]    alu_operation;
  logic [AW-1:0] ex_dest;
  logic          ex_reg_write, ex_illegal;
  logic [3:0]    ctrl;

  int errors = 0;
  int checks = 0;

  assign ctrl = {alu_a_invert, alu_b_negate, alu_operation};

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_a_invert(alu_a_invert), .alu_b_negate(alu_b_negate), .alu_operation(alu_operation),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_op = 2'b00; id_funct = '0;
    id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
    flush = 1'b0; ex_ready = 1'b1;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic drive_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [AW-1:0] rd, input logic [DW-1:0] rsd,
                             input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                             input logic src, input logic dst, input logic we);
    in_valid = 1'b1; id_alu_op = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_src = src; id_reg_dst = dst; id_reg_write = we;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    checks++; if (ctrl !== 4'b0010) begin errors++; $display("FAIL reset_ctrl got=%b exp=0010", ctrl); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_operands got a=%h b=%h exp 0/0", alu_a, alu_b); end
    checks++; if (ex_dest !== '0 || ex_reg_write !== 1'b0 || ex_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_dest_flags got dest=%0d we=%b ill=%b exp 0/0/0", ex_dest, ex_reg_write, ex_illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slt();
    drive_instr(2'b10, 6'b101010, 5'd1, 5'd2, 5'd4, 32'd5, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL slt_valid got=%b exp=1", ex_valid); end
    checks++; if (ctrl !== 4'b0111) begin errors++; $display("FAIL slt_ctrl got=%b exp=0111", ctrl); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd9) begin errors++; $display("FAIL slt_operands got a=%0d b=%0d exp 5/9", alu_a, alu_b); end
    checks++; if (ex_dest !== 5'd4 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL slt_dest got dest=%0d we=%b exp 4/1", ex_dest, ex_reg_write); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL slt_bubble got valid=%b we=%b exp 0/0", ex_valid, ex_reg_write); end
  endtask

  task automatic test_forward();
    drive_instr(2'b00, 6'd0, 5'd3, 5'd5, 5'd7, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b0, 1'b1);
    ex_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h22;
    #1;
    checks++; if (alu_a !== (FWD ? 32'h11 : 32'hAA)) begin errors++; $display("FAIL fwd_exmem_prio got=%h exp=%h", alu_a, FWD ? 32'h11 : 32'hAA); end
    checks++; if (alu_b !== 32'hBB) begin errors++; $display("FAIL fwd_rt_nomatch got=%h exp=bb", alu_b); end
    exmem_reg_write = 1'b0;
    #1;
    checks++; if (alu_a !== (FWD ? 32'h22 : 32'hAA)) begin errors++; $display("FAIL fwd_memwb got=%h exp=%h", alu_a, FWD ? 32'h22 : 32'hAA); end
    memwb_rd = 5'd5;
    #1;
    checks++; if (alu_b !== (FWD ? 32'h22 : 32'hBB) || alu_a !== 32'hAA) begin
      errors++; $display("FAIL fwd_rt_memwb got a=%h b=%h exp a=aa b=%h", alu_a, alu_b, FWD ? 32'h22 : 32'hBB); end
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; memwb_rd = 5'd3;
    #1;
    checks++; if (alu_a !== (FWD ? 32'h22 : 32'hAA) || alu_b !== (FWD ? 32'h11 : 32'hBB)) begin
      errors++; $display("FAIL fwd_split got a=%h b=%h exp a=%h b=%h", alu_a, alu_b, FWD ? 32'h22 : 32'hAA, FWD ? 32'h11 : 32'hBB); end
    // Register 0 must never take a forwarded value.
    ex_ready = 1'b1;
    drive_instr(2'b00, 6'd0, 5'd0, 5'd0, 5'd1, 32'h33, 32'h44, 32'd0, 1'b0, 1'b1, 1'b1);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (alu_a !== 32'h33 || alu_b !== 32'h44) begin errors++; $display("FAIL fwd_zero_reg got a=%h b=%h exp 33/44", alu_a, alu_b); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_stall();
    drive_instr(2'b00, 6'd0, 5'd1, 5'd6, 5'd8, 32'd7, 32'd8, 32'd0, 1'b0, 1'b0, 1'b1);
    ex_ready = 1'b0;
    @(negedge clk);
    drive_instr(2'b01, 6'd0, 5'd2, 5'd3, 5'd9, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0 || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_ready got rdy=%b valid=%b exp 0/1", in_ready, ex_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (alu_a !== 32'd7 || alu_b !== 32'd8 || ex_dest !== 5'd6 || ctrl !== 4'b0010 || ex_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold cyc=%0d got a=%0d b=%0d dest=%0d ctrl=%b v=%b exp 7/8/6/0010/1",
                           i, alu_a, alu_b, ex_dest, ctrl, ex_valid);
      end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (alu_a !== 32'd1 || alu_b !== 32'd2 || ctrl !== 4'b0110 || ex_dest !== 5'd9 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL stall_next got a=%0d b=%0d ctrl=%b dest=%0d v=%b exp 1/2/0110/9/1", alu_a, alu_b, ctrl, ex_dest, ex_valid); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    drive_instr(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_incoming got v=%b we=%b exp 0/0", ex_valid, ex_reg_write); end
    // Flush of an instruction that is stalled in EX.
    drive_instr(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
    ex_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL flush_setup got v=%b we=%b exp 1/1", ex_valid, ex_reg_write); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex_ready = 1'b1;
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_held got v=%b we=%b exp 0/0", ex_valid, ex_reg_write); end
  endtask

  task automatic test_back_to_back_decode();
    logic [1:0] ops [10];
    logic [5:0] fns [10];
    logic [3:0] exp_ctrl [10];
    logic       exp_ill [10];
    ops = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    fns = '{6'b000000, 6'b000000, 6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010, 6'b100111, 6'b000000, 6'b100000};
    exp_ctrl = '{4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000,
                 4'b0001, 4'b0111, 4'b1100, 4'b0010, 4'b0010};
    exp_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ex_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_instr(ops[i], fns[i], 5'd1, 5'd2, 5'd3, 32'(i + 100), 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (ctrl !== exp_ctrl[i] || ex_illegal !== exp_ill[i] || alu_a !== 32'(i + 100) || ex_valid !== 1'b1) begin
        errors++; $display("FAIL decode[%0d] got ctrl=%b ill=%b a=%0d v=%b exp ctrl=%b ill=%b a=%0d v=1",
                           i, ctrl, ex_illegal, alu_a, ex_valid, exp_ctrl[i], exp_ill[i], i + 100);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (ex_illegal !== 1'b0) begin errors++; $display("FAIL illegal_gated got=%b exp=0", ex_illegal); end
  endtask

  task automatic test_immediate();
    drive_instr(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 32'h10, 32'h55, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (alu_b !== 32'hFFFF_FFFC || alu_a !== 32'h10) begin errors++; $display("FAIL imm_operand got a=%h b=%h exp 10/fffffffc", alu_a, alu_b); end
    checks++; if (ex_dest !== 5'd2) begin errors++; $display("FAIL imm_dest_rt got=%0d exp=2", ex_dest); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    drive_instr(2'b01, 6'd0, 5'd4, 5'd5, 5'd6, 32'h99, 32'h98, 32'd0, 1'b0, 1'b1, 1'b1);
    ex_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h99) begin errors++; $display("FAIL rst_stall_setup got v=%b a=%h exp 1/99", ex_valid, alu_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0 || alu_a !== '0 || alu_b !== '0 || ctrl !== 4'b0010 || ex_dest !== '0) begin
      errors++; $display("FAIL rst_async got v=%b a=%h b=%h ctrl=%b dest=%0d exp 0/0/0/0010/0", ex_valid, alu_a, alu_b, ctrl, ex_dest); end
    @(negedge clk);
    rst = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_release got v=%b exp=0", ex_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_slt();
    test_forward();
    test_stall();
    test_flush();
    test_back_to_back_decode();
    test_immediate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS-32 datapath, sitting directly upstream of the 32-bit ALU. It registers decoded operands and control, and decodes ALUOp/funct into the ALU's `A_invert`/`B_negate`/`Operation` lines. It resolves EX/MEM and MEM/WB forwarding and selects the immediate, so the ALU's `A`/`B` inputs are driven straight from this block. It also provides a valid/ready handshake with stall and flush.

## Interface

Parameters:

- `DATA_W`, 32, operand width
- `REG_AW`, 5, register address width

Ports (all single-clock):

- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: ID presents an instruction
- `in_ready` out 1: stage accepts this cycle
- `id_rs_data`, `id_rt_data` in `DATA_W`: register-file read data
- `id_imm` in `DATA_W`: sign-extended immediate
- `id_rs`, `id_rt`, `id_rd` in `REG_AW`: register addresses
- `id_alu_op` in 2: 00 add, 01 sub, 10 R-type (use funct), 11 reserved
- `id_funct` in 6: instruction funct field
- `id_alu_src` in 1: 1 selects `id_imm` for B
- `id_reg_dst` in 1: 1 makes rd the destination, else rt
- `id_reg_write` in 1: instruction writes the register file
- `flush` in 1: squash the held/incoming instruction
- `ex_ready` in 1: EX/MEM accepts the current instruction
- `exmem_reg_write` in 1, `exmem_rd` in `REG_AW`, `exmem_result` in `DATA_W`: EX/MEM forward source
- `memwb_reg_write` in 1, `memwb_rd` in `REG_AW`, `memwb_data` in `DATA_W`: MEM/WB forward source
- `ex_valid` out 1: EX holds a valid instruction
- `alu_a`, `alu_b` out `DATA_W`: ALU operands
- `alu_a_invert`, `alu_b_negate` out 1, `alu_operation` out 2: ALU control
- `ex_dest` out `REG_AW`: destination register
- `ex_reg_write` out 1: write enable, gated by `ex_valid`
- `ex_illegal` out 1: unsupported ALUOp/funct, gated by `ex_valid`

## Operation

- ALU control decode, as {invert, negate, op}:
  - ALUOp 00 → 0010
  - ALUOp 01 → 0110
  - ALUOp 10 with funct 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001; 101010 → 0111; 100111 → 1100
  - Any other funct, or ALUOp 11 → 0010 and illegal=1
- Decode is performed in ID and the result is registered.
- `ex_dest` = `id_reg_dst` ? `id_rd` : `id_rt`, registered.
- Forwarding is combinational from the registered rs/rt to the current EX/MEM and MEM/WB sources:
  - Match requires `reg_write`=1, equal address, and address ≠ 0.
  - EX/MEM has priority over MEM/WB.
  - With no match, the registered RF data is used.
- `alu_a` = forwarded rs.
- `alu_b` = registered `alu_src` ? registered imm : forwarded rt.

## Timing

- Latency: 1 cycle from ID acceptance to EX outputs.
- `in_ready` = !`ex_valid` | `ex_ready`. It is combinational and independent of `flush`.
- Register loads on `in_valid` & `in_ready` & !`flush`; `ex_valid` becomes 1.
- If `ex_ready` & !load, `ex_valid` becomes 0 (bubble).
- If `ex_valid` & !`ex_ready`, all held state is frozen. Forwarding still re-evaluates every cycle.
- `flush` dominates: `ex_valid` is 0 at the next edge regardless of `in_valid` or `ex_ready`.
- Reset values (asynchronous assert, released synchronously by the surrounding reset logic):
  - `ex_valid`=0; all data registers 0
  - control=0010; `ex_dest`=0; `ex_reg_write`=0; `ex_illegal`=0
  - Therefore `alu_a` = `alu_b` = 0 unless a forward matches (rs/rt=0 never forward).
- Reset mid-stall discards the held instruction.

## Configuration

- `ID_EX_FORWARDING_EN` defined: forwarding as in Operation.
- `ID_EX_FORWARDING_EN` undefined:
  - The forward-source ports remain but are ignored.
  - `alu_a`/`alu_b` come from registered RF data and imm only.
  - Hazards are resolved by the hazard unit's stalls.

## Structure

- Shared package `mips_pkg` holds:
  - ALUOp codes
  - funct constants (ADD, SUB, AND, OR, SLT, NOR)
  - 4-bit ALU control encodings
  - `DATA_W`/`REG_AW` defaults
- Sub-module `alu_control_dec`: purely combinational ALUOp/funct → {invert, negate, op, illegal}. It is instantiated once, on the ID side of the register.

## Test plan

- Reset while holding: assert `rst` → `ex_valid`=0, `alu_operation`=2'b10, invert=0, negate=0, `alu_a`=`alu_b`=0.
- R-type SLT (funct 101010) with rs_data=5, rt_data=9, no forward matches → next cycle {0,1,11}, `alu_a`=5, `alu_b`=9.
- Forward priority: rs=3, exmem_rd=3 with 0x11, memwb_rd=3 with 0x22, both write enables set → `alu_a`=0x11; drop exmem_reg_write → 0x22. With rs=0 and all matches → registered data.
- Stall: `ex_valid`=1, `ex_ready`=0, new `in_valid` → `in_ready`=0, outputs held 3 cycles. Raise `ex_ready` → new instruction loaded next edge.
- Flush with `in_valid`=1 → `ex_valid`=0, `ex_reg_write`=0 next cycle.
- ALUOp 10 with funct 000000 → `ex_illegal`=1, control 0010. Immediate path: `alu_src`=1, imm=0xFFFFFFFC → `alu_b`=0xFFFFFFFC.
